uart_msg_top: RTL and testbench
===============================

Name: uart_msg_top

Overview:
- Self-contained UART transmitter top level that repeatedly sends the ASCII message "CSULB CECS 460 - NNNNN"<CR><LF>, where NNNNN is a 5-digit decimal message counter.
- It combines a bit-time generator, an 11-bit frame shifter, a message sequencer, an LED register and a 4-digit seven-segment multiplexer.
- It sits at the FPGA pin boundary. A 100 MHz clock is assumed for the baud divisors.

Parameters:
- REFRESH_DIV, 100000: clk cycles per seven-segment digit slot.

Ports:
- clk  in  1: system clock, 100 MHz.
- rst  in  1: reset. Single clock domain; reset is synchronous and active-high.
- EIGHT  in  1: 1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1: parity enable.
- OHEL  in  1: 1 = odd parity, 0 = even parity.
- BAUD  in  4: baud-rate select.
- TX  out  1: serial output, idle high.
- leds  out  8: message count, low 8 bits binary.
- anode  out  4: digit enables, active-low.
- sev  out  7: segments {a..g} = sev[6:0], active-low.

Behaviour:
- Reset values: TX=1, leds=0, counter=00000, sequencer at character 0, transmitter idle (TXRDY=1), anode=4'b1110, sev shows digit 0.
- Bit-time divisor, selected by BAUD (in clk cycles):
  - 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736
  - 8:868, 9:434, A:217, B–F:109
  - A divide counter runs only while transmitting. BTU is a 1-cycle pulse when the count reaches divisor-1; the count then clears.
- Frame: always 11 bit times, sent LSB first, bit0 = start (0).
  - EIGHT=1, PEN=1: d[7:0], then parity, then 1.
  - EIGHT=1, PEN=0: d[7:0], 1, 1.
  - EIGHT=0, PEN=1: d[6:0], parity, 1, 1.
  - EIGHT=0, PEN=0: d[6:0], 1, 1, 1.
  - Parity is computed over the transmitted data bits (7 or 8): even = XOR of the bits; odd = inverted XOR.
  - EIGHT, PEN, OHEL and BAUD are sampled at frame load. Changes mid-frame take effect on the next frame.
- Transmitter:
  - On load, the shift register holds the 11-bit frame, TX drives bit0 immediately, and TXRDY drops.
  - Each BTU shifts the register right, filling with 1.
  - After the 11th BTU, TX=1 and TXRDY rises. TXRDY is held high while idle.
- Sequencer:
  - Loads the next character on the cycle after TXRDY is observed high (one idle cycle between frames).
  - Characters 0–16 are "CSULB CECS 460 - ". Characters 17–21 are counter digits, most significant first, as 0x30+digit. Character 22 = 0x0D, character 23 = 0x0A. Then it wraps to character 0.
  - The digit value is the counter at the time each digit is loaded. The counter changes only when LF is loaded, so all five digits are consistent.
- Counter:
  - 5-digit BCD, incremented when LF is loaded; 99999 wraps to 00000.
  - leds is an 8-bit binary count incremented at the same instant; 255 wraps to 0.
- Seven-segment:
  - Shows the counter's lower 4 BCD digits.
  - The active anode rotates every REFRESH_DIV cycles: 1110 → 1101 → 1011 → 0111 → 1110.
  - Standard hex decode, active-low (0 → 7'b0000001).
- Reset mid-frame aborts the frame: TX returns to 1 on the next cycle and the message restarts at 'C' with counter 00000.

Test Plan:
- Reset, BAUD=B, EIGHT=PEN=OHEL=0 → first frame is 'C' (0x43). Captured bits are 0,1100001,1,1,1 (LSB first); each bit lasts 109 clks; TXRDY rises after 11×109 clks.
- Capture 24 frames → "CSULB CECS 460 - 00000\r\n". The next 24 frames give "...00001\r\n"; leds goes 00000000 → 00000001 when LF is loaded.
- Sweep {EIGHT,PEN,OHEL}=0..7, one message each → check the parity bit position and value. Example: 'C' with 8-bit even parity gives parity 1; with odd parity, 0. With PEN=0, the unused bits are 1.
- Change BAUD from B to 8 mid-frame → the current frame keeps 109-clk bits; the next frame uses 868-clk bits.
- Force the counter to 99999, send LF → counter becomes 00000; the next digits are "00000" and the 7-seg shows 0000.
- Assert rst mid-frame → TX=1 the following cycle, leds=0, and the next frame is 'C'.

Source files
------------

// File: rtl/uart_msg_top.sv
// UART message transmitter: repeatedly sends "CSULB CECS 460 - NNNNN"<CR><LF> with a BCD
// message counter, mirrors the count on LEDs and multiplexes it onto a 4-digit display.
module uart_msg_top #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  output logic       TX,
  output logic [7:0] leds,
  output logic [3:0] anode,
  output logic [6:0] sev
);

  typedef enum logic {StIdle, StBusy} tx_state_e;

  tx_state_e   state_q, state_d;
  logic [18:0] div_q, div_d, div_sel;
  logic [18:0] bt_cnt_q, bt_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [10:0] sr_q, sr_d, frame;
  logic        load, par;
  logic [7:0]  ch;
  logic [4:0]  idx_q, idx_d;
  logic [19:0] bcd_q, bcd_d;
  logic [7:0]  leds_q, leds_d;
  logic        carry;
  logic [31:0] ref_q, ref_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  digit;

  // Bit-time divisor for the selected baud rate (100 MHz clock).
  always_comb begin
    unique case (BAUD)
      4'h0:    div_sel = 19'd333333;
      4'h1:    div_sel = 19'd83333;
      4'h2:    div_sel = 19'd41667;
      4'h3:    div_sel = 19'd20833;
      4'h4:    div_sel = 19'd10417;
      4'h5:    div_sel = 19'd5208;
      4'h6:    div_sel = 19'd2604;
      4'h7:    div_sel = 19'd1736;
      4'h8:    div_sel = 19'd868;
      4'h9:    div_sel = 19'd434;
      4'hA:    div_sel = 19'd217;
      default: div_sel = 19'd109;
    endcase
  end

  // Character currently addressed by the message sequencer.
  always_comb begin
    case (idx_q)
      5'd0, 5'd6, 5'd8: ch = 8'h43;  // C
      5'd1, 5'd9:       ch = 8'h53;  // S
      5'd2:             ch = 8'h55;  // U
      5'd3:             ch = 8'h4C;  // L
      5'd4:             ch = 8'h42;  // B
      5'd7:             ch = 8'h45;  // E
      5'd11:            ch = 8'h34;  // 4
      5'd12:            ch = 8'h36;  // 6
      5'd13:            ch = 8'h30;  // 0
      5'd15:            ch = 8'h2D;  // -
      5'd17:            ch = 8'h30 + {4'h0, bcd_q[19:16]};
      5'd18:            ch = 8'h30 + {4'h0, bcd_q[15:12]};
      5'd19:            ch = 8'h30 + {4'h0, bcd_q[11:8]};
      5'd20:            ch = 8'h30 + {4'h0, bcd_q[7:4]};
      5'd21:            ch = 8'h30 + {4'h0, bcd_q[3:0]};
      5'd22:            ch = 8'h0D;
      5'd23:            ch = 8'h0A;
      default:          ch = 8'h20;  // spaces at 5, 10, 14, 16
    endcase
  end

  // Assemble the 11-bit frame (start bit in bit 0) for the sampled format.
  always_comb begin
    par = (EIGHT ? ^ch : ^ch[6:0]) ^ OHEL;
    unique case ({EIGHT, PEN})
      2'b11:   frame = {1'b1, par, ch, 1'b0};
      2'b10:   frame = {2'b11, ch, 1'b0};
      2'b01:   frame = {2'b11, par, ch[6:0], 1'b0};
      default: frame = {3'b111, ch[6:0], 1'b0};
    endcase
  end

  // Transmitter FSM: load a frame whenever idle, shift one bit per bit time.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bt_cnt_d  = bt_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        load      = 1'b1;
        sr_d      = frame;
        div_d     = div_sel;
        bt_cnt_d  = '0;
        bit_cnt_d = '0;
        state_d   = StBusy;
      end
      StBusy: begin
        if (bt_cnt_q == div_q - 19'd1) begin
          bt_cnt_d = '0;
          sr_d     = {1'b1, sr_q[10:1]};
          if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = '0;
            state_d   = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          bt_cnt_d = bt_cnt_q + 19'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer and counters advance on every frame load; LF load bumps the count.
  always_comb begin
    idx_d  = idx_q;
    bcd_d  = bcd_q;
    leds_d = leds_q;
    carry  = 1'b0;
    if (load) begin
      idx_d = (idx_q == 5'd23) ? 5'd0 : idx_q + 5'd1;
      if (idx_q == 5'd23) begin
        leds_d = leds_q + 8'd1;
        carry  = 1'b1;
        for (int i = 0; i < 5; i++) begin
          if (carry) begin
            if (bcd_q[4*i +: 4] == 4'd9) begin
              bcd_d[4*i +: 4] = 4'd0;
            end else begin
              bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
              carry           = 1'b0;
            end
          end
        end
      end
    end
  end

  // Display refresh: advance the digit slot every REFRESH_DIV cycles.
  always_comb begin
    ref_d = ref_q + 32'd1;
    sel_d = sel_q;
    if (ref_q == REFRESH_DIV - 1) begin
      ref_d = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bt_cnt_q  <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '1;
      idx_q     <= '0;
      bcd_q     <= '0;
      leds_q    <= '0;
      ref_q     <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bt_cnt_q  <= bt_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      bcd_q     <= bcd_d;
      leds_q    <= leds_d;
      ref_q     <= ref_d;
      sel_q     <= sel_d;
    end
  end

  // Digit selection and active-low hex decode for the display.
  always_comb begin
    unique case (sel_q)
      2'd0:    begin anode = 4'b1110; digit = bcd_q[3:0];   end
      2'd1:    begin anode = 4'b1101; digit = bcd_q[7:4];   end
      2'd2:    begin anode = 4'b1011; digit = bcd_q[11:8];  end
      default: begin anode = 4'b0111; digit = bcd_q[15:12]; end
    endcase
    unique case (digit)
      4'h0: sev = 7'b0000001;
      4'h1: sev = 7'b1001111;
      4'h2: sev = 7'b0010010;
      4'h3: sev = 7'b0000110;
      4'h4: sev = 7'b1001100;
      4'h5: sev = 7'b0100100;
      4'h6: sev = 7'b0100000;
      4'h7: sev = 7'b0001111;
      4'h8: sev = 7'b0000000;
      4'h9: sev = 7'b0000100;
      4'hA: sev = 7'b0001000;
      4'hB: sev = 7'b1100000;
      4'hC: sev = 7'b0110001;
      4'hD: sev = 7'b1000010;
      4'hE: sev = 7'b0110000;
      default: sev = 7'b0111000;
    endcase
  end

  assign TX   = sr_q[0];
  assign leds = leds_q;

endmodule

// File: tb/tb_uart_msg_top.sv
// Scoreboard bench for uart_msg_top: a stimulus process predicts each frame from a
// high-level message model; a monitor decodes TX bit by bit and checks against the queue.
module tb_uart_msg_top;

  localparam int unsigned RDIV = 16;

  logic       clk = 1'b0;
  logic       rst, EIGHT, PEN, OHEL;
  logic [3:0] BAUD;
  logic       TX;
  logic [7:0] leds;
  logic [3:0] anode;
  logic [6:0] sev;

  uart_msg_top #(.REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL), .BAUD(BAUD),
    .TX(TX), .leds(leds), .anode(anode), .sev(sev)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] bits;
    int          period;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   gen = 0;
  int   m_g0;
  bit   m_abort;
  bit   mon_busy = 0;
  int   m_idx, m_cnt, m_leds;
  int   st_cs, st_per;
  int   pw[5] = '{1, 10, 100, 1000, 10000};
  string hdr = "CSULB CECS 460 - ";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int div_of(input logic [3:0] b);
    case (b)
      4'h0: return 333333; 4'h1: return 83333; 4'h2: return 41667; 4'h3: return 20833;
      4'h4: return 10417;  4'h5: return 5208;  4'h6: return 2604;  4'h7: return 1736;
      4'h8: return 868;    4'h9: return 434;   4'hA: return 217;   default: return 109;
    endcase
  endfunction

  function automatic logic [7:0] char_of(input int idx, input int cnt);
    if (idx < 17) return hdr.getc(idx);
    if (idx < 22) return 8'(48 + (cnt / pw[21 - idx]) % 10);
    if (idx == 22) return 8'h0D;
    return 8'h0A;
  endfunction

  // Start bit, data LSB first, optional parity, then 1s up to 11 bit times.
  function automatic logic [10:0] frame_of(input logic [7:0] c, input logic e, input logic p,
                                           input logic o);
    logic [10:0] f;
    int n, k, ones;
    f = '1;
    f[0] = 1'b0;
    n = e ? 8 : 7;
    k = 1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f[k] = c[i];
      if (c[i]) ones++;
      k++;
    end
    if (p) f[k] = logic'(ones % 2) ^ o;
    return f;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001; 1: return 7'b1001111; 2: return 7'b0010010; 3: return 7'b0000110;
      4: return 7'b1001100; 5: return 7'b0100100; 6: return 7'b0100000; 7: return 7'b0001111;
      8: return 7'b0000000; default: return 7'b0000100;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0; 4'b1101: return 1; 4'b1011: return 2; 4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic mwait(input int n);
    for (int j = 0; j < n && !m_abort; j++) begin
      @(negedge clk);
      if (gen != m_g0) m_abort = 1;
    end
  endtask

  task automatic wait_fall(input int min_cyc, output bit ok);
    ok = 0;
    while (cyc < min_cyc) @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (TX === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Called on the first cycle of a frame: predict it and check count/display state.
  task automatic on_frame();
    exp_t e;
    int s;
    e.bits   = frame_of(char_of(m_idx, m_cnt), EIGHT, PEN, OHEL);
    e.period = div_of(BAUD);
    if (m_idx == 23) begin
      m_cnt  = (m_cnt + 1) % 100000;
      m_leds = (m_leds + 1) % 256;
    end
    m_idx = (m_idx + 1) % 24;
    st_cs  = cyc;
    st_per = e.period;
    q.push_back(e);
    check("leds", leds, m_leds);
    s = slot_of(anode);
    check("anode_valid", s >= 0, 1);
    if (s >= 0) check("sev_digit", sev, seg_of((m_cnt / pw[s]) % 10));
  endtask

  // Monitor: decode each frame off TX, check every bit at both ends of its bit time.
  initial begin : monitor
    exp_t e;
    logic [10:0] got;
    int unstable, ps, prev_start, prev_per;
    bit have_prev;
    have_prev = 0;
    prev_start = 0;
    prev_per = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || TX !== 1'b0) continue;
      mon_busy = 1;
      m_g0 = gen;
      m_abort = 0;
      ps = cyc;
      got = '1;
      unstable = 0;
      got[0] = TX;
      mwait(1);
      check("frame_expected", q.size() != 0, 1);
      if (q.size() == 0) begin
        mon_busy = 0;
        have_prev = 0;
        continue;
      end
      e = q.pop_front();
      if (have_prev) check("frame_gap", ps - prev_start, 11 * prev_per + 1);
      mwait(e.period - 2);
      if (TX !== got[0]) unstable++;
      for (int i = 1; i < 11; i++) begin
        mwait(1);
        got[i] = TX;
        mwait(e.period - 1);
        if (TX !== got[i]) unstable++;
      end
      if (!m_abort) begin
        check("frame_bits", got, e.bits);
        check("bit_stable", unstable, 0);
        have_prev = 1;
        prev_start = ps;
        prev_per = e.period;
      end else begin
        have_prev = 0;
      end
      mon_busy = 0;
    end
  end

  // Stimulus: three messages' worth of frames, format sweep, baud change, reset abort.
  initial begin : stimulus
    bit ok;
    int n, d;
    logic [2:0] cfg;
    logic [3:0] a0;
    rst = 1'b1;
    EIGHT = 1'b0;
    PEN = 1'b0;
    OHEL = 1'b0;
    BAUD = 4'hB;
    m_idx = 0;
    m_cnt = 0;
    m_leds = 0;
    st_cs = 0;
    st_per = 0;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_leds", leds, 0);
    check("rst_anode", anode, 4'b1110);
    check("rst_sev", sev, seg_of(0));
    rst = 1'b0;
    st_cs = cyc;
    for (int f = 0; f < 51; f++) begin
      wait_fall(st_cs + 10 * st_per, ok);
      check("start_seen", ok, 1);
      if (!ok) break;
      on_frame();
      if (f == 1) begin
        a0 = anode;
        repeat (RDIV) @(negedge clk);
        check("anode_rotate", anode, {a0[2:0], a0[3]});
      end
      if (f == 24) begin
        force dut.bcd_q = 20'h99999;
        @(negedge clk);
        release dut.bcd_q;
        m_cnt = 99999;
      end
      if (f >= 23 && f <= 47) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        n = f + 1 - 24;
        if (f == 47) cfg = 3'd0;
        else if (n < 8) cfg = 3'(n);
        else cfg = 3'($urandom_range(0, 7));
        {EIGHT, PEN, OHEL} = cfg;
      end
      if (f == 47) begin
        for (int s = 0; s < 4; s++) begin
          a0 = anode;
          repeat (RDIV) @(negedge clk);
          check("wrap_anode", anode, {a0[2:0], a0[3]});
          check("wrap_sev", sev, seg_of(0));
        end
      end
      if (f == 48) begin
        repeat ($urandom_range(5, 500)) @(negedge clk);
        BAUD = 4'h8;
      end
      if (f == 50) begin
        BAUD = 4'hB;
        d = $urandom_range(5, 700);
        repeat (d) @(negedge clk);
        check("tx_start_bit", TX, 0);
        rst = 1'b1;
        gen++;
        @(negedge clk);
        check("abort_tx", TX, 1);
        check("abort_leds", leds, 0);
        check("abort_anode", anode, 4'b1110);
        check("abort_sev", sev, seg_of(0));
        rst = 1'b0;
        m_idx = 0;
        m_cnt = 0;
        m_leds = 0;
        wait_fall(cyc, ok);
        check("restart_seen", ok, 1);
        if (ok) on_frame();
      end
    end
    for (int i = 0; i < 3000 && (q.size() != 0 || mon_busy); i++) @(negedge clk);
    check("drained", q.size() == 0 && !mon_busy, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
